// File: rtl/hht_csr_pack.sv
// hht_csr_pack -- streams a dense ROWS x ROW_LEN matrix (row-major) and emits
// it in CSR form: value writes (WR1/addr1/dataOut1), column-index writes
// (WR2/addr2/dataOut2) and row-pointer writes (rptr_wr/rptr_addr/rptr_data).
//
// Ports:
//   Clk, Rst                      rising-edge clock, synchronous active-high reset
//   start                         begin packing one matrix (honoured in IDLE only)
//   base_val/base_col/base_row    base addresses, latched on start
//   din_valid/din/din_ready       dense element stream, one element per handshake
//   WR1/addr1/dataOut1            value-array write (1-cycle after acceptance)
//   WR2/addr2/dataOut2            column-array write (same cycle as WR1)
//   rptr_wr/rptr_addr/rptr_data   row-pointer write
//   busy, done                    RUN indicator, one-cycle completion pulse
//   nnz_count                     nonzeros written so far; held until next start
//
// Build option: define HHT_PACK_ROWPTR_EN to produce row-pointer writes; when
// undefined the rptr_* outputs are tied to 0 and everything else is identical.
module hht_csr_pack #(
  parameter int ROW_LEN = 16,
  parameter int ROWS    = 16,
  parameter int AW      = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start,
  input  logic [AW-1:0] base_val,
  input  logic [AW-1:0] base_col,
  input  logic [AW-1:0] base_row,
  input  logic          din_valid,
  input  logic [AW-1:0] din,
  output logic          din_ready,
  output logic          WR1,
  output logic [AW-1:0] addr1,
  output logic [AW-1:0] dataOut1,
  output logic          WR2,
  output logic [AW-1:0] addr2,
  output logic [AW-1:0] dataOut2,
  output logic          rptr_wr,
  output logic [AW-1:0] rptr_addr,
  output logic [AW-1:0] rptr_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] nnz_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [AW-1:0] bv, bc;
  logic [AW-1:0] col, row, nnz;

  logic accept, nz, last_col, last_elem, launch;

  assign launch    = (state == IDLE) && start;
  assign accept    = (state == RUN) && din_valid;
  assign nz        = (din != '0);
  assign last_col  = (col == AW'(ROW_LEN - 1));
  assign last_elem = last_col && (row == AW'(ROWS - 1));

  assign din_ready = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign nnz_count = nnz;

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && last_elem) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Value/column datapath. Strobes default low every cycle so they are
  // single-cycle pulses; addr/data only move when a write is issued.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      bv       <= '0;
      bc       <= '0;
      col      <= '0;
      row      <= '0;
      nnz      <= '0;
      WR1      <= 1'b0;
      WR2      <= 1'b0;
      addr1    <= '0;
      dataOut1 <= '0;
      addr2    <= '0;
      dataOut2 <= '0;
    end else begin
      WR1 <= 1'b0;
      WR2 <= 1'b0;
      if (launch) begin
        bv  <= base_val;
        bc  <= base_col;
        col <= '0;
        row <= '0;
        nnz <= '0;
      end else if (accept) begin
        if (nz) begin
          WR1      <= 1'b1;
          WR2      <= 1'b1;
          addr1    <= bv + nnz;
          dataOut1 <= din;
          addr2    <= bc + nnz;
          dataOut2 <= col;
          nnz      <= nnz + 1'b1;
        end
        if (last_col) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

`ifdef HHT_PACK_ROWPTR_EN
  logic [AW-1:0] br;

  // Row pointer k+1 is written as row k closes; its value must count the
  // closing element, which nnz has not absorbed yet this cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      br        <= '0;
      rptr_wr   <= 1'b0;
      rptr_addr <= '0;
      rptr_data <= '0;
    end else begin
      rptr_wr <= 1'b0;
      if (launch) begin
        br        <= base_row;
        rptr_wr   <= 1'b1;
        rptr_addr <= base_row;
        rptr_data <= '0;
      end else if (accept && last_col) begin
        rptr_wr   <= 1'b1;
        rptr_addr <= br + row + 1'b1;
        rptr_data <= nnz + {{(AW-1){1'b0}}, nz};
      end
    end
  end
`else
  logic unused_rptr;
  assign unused_rptr = ^base_row;
  assign rptr_wr     = 1'b0;
  assign rptr_addr   = '0;
  assign rptr_data   = '0;
`endif

endmodule

// File: tb/tb_hht_csr_pack.sv
module tb_hht_csr_pack;
  localparam int ROW_LEN = 16;
  localparam int ROWS    = 16;
  localparam int AW      = 32;
`ifdef HHT_PACK_ROWPTR_EN
  localparam bit RP = 1'b1;
`else
  localparam bit RP = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst, start, din_valid;
  logic [AW-1:0] base_val, base_col, base_row, din;
  logic          din_ready, WR1, WR2, rptr_wr, busy, done;
  logic [AW-1:0] addr1, dataOut1, addr2, dataOut2, rptr_addr, rptr_data, nnz_count;

  hht_csr_pack #(.ROW_LEN(ROW_LEN), .ROWS(ROWS), .AW(AW)) dut (
    .Clk(Clk), .Rst(Rst), .start(start),
    .base_val(base_val), .base_col(base_col), .base_row(base_row),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .WR1(WR1), .addr1(addr1), .dataOut1(dataOut1),
    .WR2(WR2), .addr2(addr2), .dataOut2(dataOut2),
    .rptr_wr(rptr_wr), .rptr_addr(rptr_addr), .rptr_data(rptr_data),
    .busy(busy), .done(done), .nnz_count(nnz_count)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".din_ready"}, din_ready, 0);
    chk({tag, ".WR1"}, WR1, 0);
    chk({tag, ".WR2"}, WR2, 0);
    chk({tag, ".rptr_wr"}, rptr_wr, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".addr1"}, addr1, 0);
    chk({tag, ".dataOut1"}, dataOut1, 0);
    chk({tag, ".addr2"}, addr2, 0);
    chk({tag, ".dataOut2"}, dataOut2, 0);
    chk({tag, ".rptr_addr"}, rptr_addr, 0);
    chk({tag, ".rptr_data"}, rptr_data, 0);
    chk({tag, ".nnz_count"}, nnz_count, 0);
  endtask

  // Scoreboard: expected writes are queued as elements are driven and popped
  // as strobes appear; an unexpected strobe finds an empty queue.
  typedef struct { logic [AW-1:0] a1, d1, a2, d2; } vw_t;
  typedef struct { logic [AW-1:0] a, d; } rw_t;
  vw_t q_v[$];
  rw_t q_r[$];
  vw_t mv;
  rw_t mr;
  bit mon_en = 1'b0;
  int wr_cnt = 0, rp_cnt = 0, done_cnt = 0;
  logic [AW-1:0] last_rd = '0;

  always @(negedge Clk) begin
    if (mon_en) begin
      if (done) done_cnt++;
      if (WR1 || WR2) begin
        wr_cnt++;
        chk("sb.wr_pair", WR2, WR1);
        if (q_v.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb.extra_wr: got addr1 %0h with no expected write", addr1);
        end else begin
          mv = q_v.pop_front();
          chk("sb.addr1", addr1, mv.a1);
          chk("sb.dataOut1", dataOut1, mv.d1);
          chk("sb.addr2", addr2, mv.a2);
          chk("sb.dataOut2", dataOut2, mv.d2);
        end
      end
      if (rptr_wr) begin
        rp_cnt++;
        last_rd = rptr_data;
        if (q_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb.extra_rptr: got rptr_addr %0h with no expected write", rptr_addr);
        end else begin
          mr = q_r.pop_front();
          chk("sb.rptr_addr", rptr_addr, mr.a);
          chk("sb.rptr_data", rptr_data, mr.d);
        end
      end
    end
  end

  typedef struct {
    logic [AW-1:0] din;
    logic          wr;
    logic [AW-1:0] a1, d1, a2, d2;
    logic          rw;
    logic [AW-1:0] ra, rd;
  } tv_t;
  tv_t tv[16];

  initial begin
    logic [AW-1:0] m_nnz, v, bv, bc, br;
    int col, row;

    // Row 0 of the basic scenario: 7,12,0,11 then twelve zeros.
    tv[0] = '{32'd7,  1'b1, 32'd2, 32'd7,  32'd180, 32'd0, 1'b0, RP ? 32'd400 : 32'd0, 32'd0};
    tv[1] = '{32'd12, 1'b1, 32'd3, 32'd12, 32'd181, 32'd1, 1'b0, RP ? 32'd400 : 32'd0, 32'd0};
    tv[2] = '{32'd0,  1'b0, 32'd3, 32'd12, 32'd181, 32'd1, 1'b0, RP ? 32'd400 : 32'd0, 32'd0};
    tv[3] = '{32'd11, 1'b1, 32'd4, 32'd11, 32'd182, 32'd3, 1'b0, RP ? 32'd400 : 32'd0, 32'd0};
    for (int i = 4; i < 16; i++)
      tv[i] = '{32'd0, 1'b0, 32'd4, 32'd11, 32'd182, 32'd3, 1'b0, RP ? 32'd400 : 32'd0, 32'd0};
    tv[15].rw = RP;
    tv[15].ra = RP ? 32'd401 : 32'd0;
    tv[15].rd = RP ? 32'd3 : 32'd0;

    Rst = 1'b1; start = 1'b0; din_valid = 1'b0; din = '0;
    base_val = '0; base_col = '0; base_row = '0;
    tick(); tick();
    check_all_zero("reset");

    // Basic start and row 0.
    Rst = 1'b0;
    base_val = 32'd2; base_col = 32'd180; base_row = 32'd400;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start.busy", busy, 1);
    chk("start.din_ready", din_ready, 1);
    chk("start.rptr_wr", rptr_wr, RP);
    chk("start.rptr_addr", rptr_addr, RP ? 32'd400 : 32'd0);
    chk("start.rptr_data", rptr_data, 0);
    chk("start.nnz", nnz_count, 0);
    for (int i = 0; i < 16; i++) begin
      din_valid = 1'b1; din = tv[i].din;
      tick();
      chk($sformatf("row0[%0d].WR1", i), WR1, tv[i].wr);
      chk($sformatf("row0[%0d].WR2", i), WR2, tv[i].wr);
      chk($sformatf("row0[%0d].addr1", i), addr1, tv[i].a1);
      chk($sformatf("row0[%0d].dataOut1", i), dataOut1, tv[i].d1);
      chk($sformatf("row0[%0d].addr2", i), addr2, tv[i].a2);
      chk($sformatf("row0[%0d].dataOut2", i), dataOut2, tv[i].d2);
      chk($sformatf("row0[%0d].rptr_wr", i), rptr_wr, tv[i].rw);
      chk($sformatf("row0[%0d].rptr_addr", i), rptr_addr, tv[i].ra);
      chk($sformatf("row0[%0d].rptr_data", i), rptr_data, tv[i].rd);
    end
    chk("row0.nnz", nnz_count, 3);
    // Stall: nothing moves, strobes low.
    din_valid = 1'b0; din = 32'd55;
    tick();
    chk("stall.WR1", WR1, 0);
    chk("stall.rptr_wr", rptr_wr, 0);
    chk("stall.addr1", addr1, 4);
    chk("stall.nnz", nnz_count, 3);

    // Reset mid-RUN after 5 accepted elements, then a fresh start.
    Rst = 1'b1; tick(); Rst = 1'b0;
    base_val = 32'd50; base_col = 32'd60; base_row = 32'd70;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      din_valid = 1'b1; din = AW'(i);
      tick();
    end
    din_valid = 1'b0;
    chk("pre_rst.nnz", nnz_count, 5);
    Rst = 1'b1;
    tick();
    check_all_zero("mid_run_rst");
    Rst = 1'b0;
    tick();
    chk("post_rst.WR1", WR1, 0);
    chk("post_rst.busy", busy, 0);
    base_val = 32'd100; base_col = 32'd300;
    start = 1'b1; tick(); start = 1'b0;
    din_valid = 1'b1; din = 32'd9;
    tick();
    din_valid = 1'b0;
    chk("fresh.WR1", WR1, 1);
    chk("fresh.addr1", addr1, 100);
    chk("fresh.dataOut1", dataOut1, 9);
    chk("fresh.addr2", addr2, 300);
    chk("fresh.dataOut2", dataOut2, 0);
    chk("fresh.nnz", nnz_count, 1);

    // Full matrix, 40 nonzeros, valid every other cycle, value base wraps.
    Rst = 1'b1; tick(); Rst = 1'b0;
    bv = 32'hFFFF_FFF8; bc = 32'h1000; br = 32'h2000;
    base_val = bv; base_col = bc; base_row = br;
    mon_en = 1'b1;
    if (RP) q_r.push_back('{br, 32'd0});
    start = 1'b1; tick(); start = 1'b0;
    m_nnz = '0;
    for (int idx = 0; idx < ROWS * ROW_LEN; idx++) begin
      col = idx % ROW_LEN;
      row = idx / ROW_LEN;
      v = ((idx % 6 == 3) && (idx < 240)) ? AW'(idx + 1) : '0;
      if (idx % 2 == 1) begin
        din_valid = 1'b0; din = $urandom;
        if (idx == 101) begin
          start = 1'b1; base_val = 32'h5555; base_col = 32'h6666; base_row = 32'h7777;
        end
        tick();
        start = 1'b0; base_val = bv; base_col = bc; base_row = br;
      end
      if (idx == 128) chk("full.din_ready", din_ready, 1);
      din_valid = 1'b1; din = v;
      if (v != '0) begin
        q_v.push_back('{bv + m_nnz, v, bc + m_nnz, AW'(col)});
        m_nnz = m_nnz + 1;
      end
      if (RP && col == ROW_LEN - 1) q_r.push_back('{br + AW'(row) + 1, m_nnz});
      tick();
    end
    din_valid = 1'b0;
    chk("full.done", done, 1);
    chk("full.busy_in_done", busy, 0);
    start = 1'b1;                       // ignored in DONE
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    mon_en = 1'b0;
    chk("full.idle_busy", busy, 0);
    chk("full.wr_cnt", wr_cnt, 40);
    chk("full.rptr_cnt", rp_cnt, RP ? 32'd17 : 32'd0);
    chk("full.last_rptr_data", last_rd, RP ? 32'd40 : 32'd0);
    chk("full.done_cnt", done_cnt, 1);
    chk("full.nnz", nnz_count, 40);
    chk("full.q_v_left", q_v.size(), 0);
    chk("full.q_r_left", q_r.size(), 0);
    chk("full.model_nnz", nnz_count, m_nnz);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hht_csr_pack.md
HHT_CSR_PACK -- requirements
Module: hht_csr_pack

Interface
REQ-001 SHALL have parameters: ROW_LEN, default 16, dense elements per row; ROWS, default 16, rows per matrix; AW, default 32, address/data width.
REQ-002 SHALL have one clock and a synchronous, active-high reset: Clk  input  1  rising-edge clock; Rst  input  1  synchronous active-high reset.
REQ-003 SHALL have ports (name  direction  width  meaning):
- start  input  1  begin packing one matrix.
- base_val, base_col, base_row  input  AW each  base addresses of the value, column-index and row-pointer arrays.
- din_valid  input  1  dense element offered.
- din  input  AW  dense element value, row-major order.
- din_ready  output  1  element accepted when din_valid and din_ready are both high.
- WR1  output  1  value-array write strobe; addr1  output  AW; dataOut1  output  AW.
- WR2  output  1  column-array write strobe; addr2  output  AW; dataOut2  output  AW.
- rptr_wr  output  1  row-pointer write strobe; rptr_addr  output  AW; rptr_data  output  AW.
- busy  output  1  high in RUN.
- done  output  1  one-cycle completion pulse.
- nnz_count  output  AW  nonzero elements written so far.

Function
REQ-004 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-005 IDLE->RUN SHALL occur on start; in the same edge, base addresses are latched, col/row/nnz counters are cleared, and rptr_wr=1, rptr_addr=base_row, rptr_data=0 are registered.
REQ-006 din_ready SHALL equal 1 only in RUN; in IDLE and DONE, din is ignored.
REQ-007 On an accepted element with din!=0, the next cycle SHALL show WR1=WR2=1, addr1=base_val+nnz, dataOut1=din, addr2=base_col+nnz, dataOut2=col; nnz then increments.
REQ-008 An accepted element with din==0 SHALL produce no value or column write; col still advances.
REQ-009 When col==ROW_LEN-1 is accepted, col SHALL wrap to 0 and row SHALL increment; the next cycle SHALL show rptr_wr=1, rptr_addr=base_row+row+1, rptr_data=nnz including that element.
REQ-010 When the final element (row ROWS-1, col ROW_LEN-1) is accepted, the FSM SHALL go RUN->DONE; done=1 for exactly one cycle; DONE->IDLE is unconditional.
REQ-011 All write outputs SHALL be registered with 1-cycle latency from acceptance, and strobes SHALL be single-cycle pulses; WR1, WR2 and rptr_wr may assert in the same cycle.
REQ-012 din_valid low in RUN SHALL stall with counters and outputs held, and strobes SHALL be 0.
REQ-013 start while in RUN or DONE SHALL be ignored.
REQ-014 nnz_count SHALL hold its final value until the next accepted start.
REQ-015 Address arithmetic SHALL be modulo 2^AW, with wrap permitted.
REQ-016 When no write strobe is active, addr/data outputs SHALL hold their last values.

Reset
REQ-017 Rst=1 at a rising edge SHALL force IDLE, clear all counters, and drive every output to 0 (din_ready, WR1, WR2, rptr_wr, busy, done, addresses, data, nnz_count), including mid-RUN.
REQ-018 After reset, no pending write from before reset SHALL be issued.

Configuration
REQ-019 Macro HHT_PACK_ROWPTR_EN: when defined, the row-pointer writes of REQ-005/REQ-009 SHALL be produced; when undefined, rptr_wr, rptr_addr and rptr_data SHALL be constant 0 and all other behaviour SHALL be unchanged.

Verification
REQ-020 Reset then start with base_val=2, base_col=180, base_row=400 -> next cycle shows rptr_wr=1, rptr_addr=400, rptr_data=0, busy=1.
REQ-021 Row 0 = 7,12,0,11,0 x12 -> value writes (2,7),(3,12),(4,11); column writes (180,0),(181,1),(182,3); rptr write (401,3).
REQ-022 Full 16x16 matrix with 40 nonzeros, din_valid toggled every other cycle -> 40 WR1/WR2 pulses, 17 rptr writes, last rptr_data=40, one done pulse, nnz_count=40.
REQ-023 Rst asserted after 5 accepted elements -> all outputs 0 next cycle; a fresh start gives nnz from 0 with addr1=base_val.
REQ-024 start pulsed during RUN -> no counter or base change; the matrix completes normally.
REQ-025 Build without HHT_PACK_ROWPTR_EN, scenario REQ-021 -> identical WR1/WR2 traffic, rptr_wr never 1.
